// File: rtl/timer_sched_pkg.sv
// Shared types and constants for the timer_sched round-robin timer scheduler.
package timer_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam int NREQ_MAX = 16;
    localparam int IDX_W    = $clog2(NREQ_MAX);

    // After reset the pointer sits on the last requester, so index 0 is searched first.
    function automatic logic [IDX_W-1:0] ptr_rst_val(input int nreq);
        return IDX_W'(nreq - 1);
    endfunction

endpackage

// File: rtl/timer_sched_rr_arbiter.sv
// Combinational round-robin pick: search starts at ptr_i+1 and wraps modulo NREQ.
module rr_arbiter
    import timer_sched_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [NREQ-1:0]  gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    localparam int LW = $clog2(NREQ);

    always_comb begin
        int  j;
        logic found;
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 1; k <= NREQ; k++) begin
            j = (int'(ptr_i) + k) % NREQ;
            if (!found && req_i[LW'(j)]) begin
                found            = 1'b1;
                gnt_o[LW'(j)]    = 1'b1;
                idx_o            = IDX_W'(j);
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/timer_sched.sv
// Round-robin scheduler sharing one one-shot timer between NREQ requesters.
// Optional TIMER_SCHED_CANCEL_EN adds cancel/aborted for owner-initiated abort.
module timer_sched
    import timer_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] load_val,
    output logic [NREQ-1:0]   grant,
    output logic [NREQ-1:0]   done,
    output logic              busy,
    output logic              timer_enable,
    output logic [W-1:0]      timer_load,
    input  logic              timer_timeout,
    input  logic [W-1:0]      timer_value,
    output logic [W-1:0]      remaining
`ifdef TIMER_SCHED_CANCEL_EN
    ,
    input  logic [NREQ-1:0]   cancel,
    output logic              aborted
`endif
);

    // state   | meaning
    // IDLE    | waiting for any req; arbiter picks owner
    // LOAD    | timer captures latched delay (enable low)
    // RUN     | timer counting down until timeout
    // DONE    | one-cycle done pulse to owner, pointer advanced

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [W-1:0]       load_q, load_d;
    logic [W-1:0]       load_sel;
    logic [NREQ-1:0]    arb_gnt;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_valid;
    logic [NREQ-1:0]    owner_oh;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    always_comb begin
        load_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_gnt[i]) load_sel = load_val[i*W +: W];
        end
    end

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            owner_oh[i] = (owner_q == IDX_W'(i));
        end
    end

`ifdef TIMER_SCHED_CANCEL_EN
    logic cancel_hit;
    logic aborted_q, aborted_d;
    assign cancel_hit = |(cancel & owner_oh);
    assign aborted    = aborted_q;
`endif

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        load_d  = load_q;
`ifdef TIMER_SCHED_CANCEL_EN
        aborted_d = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    state_d = ST_LOAD;
                    owner_d = arb_idx;
                    load_d  = load_sel;
                end
            end
            ST_LOAD: begin
                state_d = ST_RUN;
`ifdef TIMER_SCHED_CANCEL_EN
                if (cancel_hit) begin
                    state_d   = ST_DONE;
                    aborted_d = 1'b1;
                end
`endif
            end
            ST_RUN: begin
                // A timeout in the same cycle as cancel counts as a normal completion.
                if (timer_timeout) begin
                    state_d = ST_DONE;
                end
`ifdef TIMER_SCHED_CANCEL_EN
                else if (cancel_hit) begin
                    state_d   = ST_DONE;
                    aborted_d = 1'b1;
                end
`endif
            end
            ST_DONE: begin
                ptr_d   = owner_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        grant        = '0;
        done         = '0;
        busy         = (state_q != ST_IDLE);
        timer_enable = 1'b0;
        timer_load   = load_q;
        remaining    = '0;
        unique case (state_q)
            ST_LOAD: grant = owner_oh;
            ST_RUN: begin
                grant        = owner_oh;
                timer_enable = 1'b1;
                remaining    = timer_value;
            end
            ST_DONE: begin
                grant = owner_oh;
                done  = owner_oh;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            ptr_q   <= ptr_rst_val(NREQ);
            load_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            load_q  <= load_d;
        end
    end

`ifdef TIMER_SCHED_CANCEL_EN
    always_ff @(posedge clk) begin
        if (!rst) aborted_q <= 1'b0;
        else      aborted_q <= aborted_d;
    end
`endif

endmodule

// File: tb/tb_timer_sched.sv
// Directed self-checking bench for timer_sched with a behavioural one-shot timer.
module tb_timer_sched;

    localparam int NREQ = 4;
    localparam int W    = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] load_val;
    logic [NREQ-1:0]   grant, done;
    logic              busy, timer_enable, timer_timeout;
    logic [W-1:0]      timer_load, timer_value, remaining;
    logic [W-1:0]      tmr_q = '0;
`ifdef TIMER_SCHED_CANCEL_EN
    logic [NREQ-1:0]   cancel;
    logic              aborted;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    timer_sched #(.NREQ(NREQ), .W(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .load_val      (load_val),
        .grant         (grant),
        .done          (done),
        .busy          (busy),
        .timer_enable  (timer_enable),
        .timer_load    (timer_load),
        .timer_timeout (timer_timeout),
        .timer_value   (timer_value),
        .remaining     (remaining)
`ifdef TIMER_SCHED_CANCEL_EN
        ,
        .cancel        (cancel),
        .aborted       (aborted)
`endif
    );

    // Reference timer: capture while disabled, saturating down-count while enabled.
    always @(posedge clk) begin
        if (!timer_enable)   tmr_q <= timer_load;
        else if (tmr_q != 0) tmr_q <= tmr_q - 1'b1;
    end
    assign timer_value   = tmr_q;
    assign timer_timeout = timer_enable && (tmr_q == '0);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_grant"}, grant, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_en"}, timer_enable, 0);
        check({tag, "_tload"}, timer_load, 0);
        check({tag, "_rem"}, remaining, 0);
`ifdef TIMER_SCHED_CANCEL_EN
        check({tag, "_aborted"}, aborted, 0);
`endif
    endtask

    // Called at the negedge just before the edge that samples req in IDLE (edge t).
    // mid: 0 none, 1 overwrite load_val[idx] with mid_val in RUN, 2 drop req[idx] in RUN.
    task automatic run_txn(input int idx, input int L, input int mid, input int mid_val, input bit drop);
        logic [NREQ-1:0] oh;
        logic            early;
        oh      = '0;
        oh[idx] = 1'b1;
        step();
        check("load_grant", grant, oh);
        check("load_tload", timer_load, L);
        check("load_en", timer_enable, 0);
        check("load_busy", busy, 1);
        step();
        check("run_en", timer_enable, 1);
        check("run_grant", grant, oh);
        check("run_rem", remaining, L);
        if (mid == 1)      load_val[idx*W +: W] = W'(mid_val);
        else if (mid == 2) req[idx] = 1'b0;
        early = 1'b0;
        for (int i = 0; i < L; i++) begin
            if (timer_timeout || done != 0 || !timer_enable) early = 1'b1;
            step();
        end
        check("no_early_done", early, 0);
        check("timeout", timer_timeout, 1);
        check("timeout_nodone", done, 0);
        step();
        check("done", done, oh);
        check("done_en", timer_enable, 0);
`ifdef TIMER_SCHED_CANCEL_EN
        check("done_aborted", aborted, 0);
`endif
        if (drop) req[idx] = 1'b0;
        step();
        check("idle_busy", busy, 0);
        check("idle_grant", grant, 0);
    endtask

    initial begin
        logic seen;
        rst      = 1'b0;
        req      = '0;
        load_val = '0;
`ifdef TIMER_SCHED_CANCEL_EN
        cancel   = '0;
`endif
        step(3);
        check_all_zero("rst");
        rst = 1'b1;
        step();

        load_val[1*W +: W] = 8'd10;  req = 4'b0010;  run_txn(1, 10, 0, 0, 1);
        load_val[0*W +: W] = 8'd0;   req[0] = 1'b1;  run_txn(0, 0, 0, 0, 1);
        load_val[0*W +: W] = 8'd5;   req[0] = 1'b1;  run_txn(0, 5, 1, 99, 1);
        load_val[3*W +: W] = 8'd2;   req[3] = 1'b1;  run_txn(3, 2, 2, 0, 1);
        load_val[1*W +: W] = 8'd255; req[1] = 1'b1;  run_txn(1, 255, 0, 0, 1);

        rst = 1'b0;
        step(2);
        rst = 1'b1;
        for (int i = 0; i < NREQ; i++) load_val[i*W +: W] = 8'd3;
        req = 4'b1111;
        run_txn(0, 3, 0, 0, 0);
        run_txn(1, 3, 0, 0, 0);
        run_txn(2, 3, 0, 0, 0);
        run_txn(3, 3, 0, 0, 0);
        run_txn(0, 3, 0, 0, 0);
        req = '0;
        step();

        load_val[2*W +: W] = 8'd1;  req = 4'b0100;  run_txn(2, 1, 0, 0, 1);

        load_val[3*W +: W] = 8'd50; req = 4'b1000;
        step(5);
        check("rm_running", timer_enable, 1);
        rst = 1'b0;
        req = '0;
        step();
        check_all_zero("rm");
        rst  = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (done != 0 || busy) seen = 1'b1;
        end
        check("rm_no_done", seen, 0);
        load_val[2*W +: W] = 8'd4;
        load_val[3*W +: W] = 8'd6;
        req = 4'b1100;
        run_txn(2, 4, 0, 0, 1);
        run_txn(3, 6, 0, 0, 1);

`ifdef TIMER_SCHED_CANCEL_EN
        load_val[0*W +: W] = 8'd100;
        req = 4'b0001;
        step(4);
        cancel = 4'b0010;
        step();
        cancel = '0;
        check("cx_nonowner_en", timer_enable, 1);
        check("cx_nonowner_done", done, 0);
        step(2);
        cancel = 4'b0001;
        step();
        check("cx_done", done, 4'b0001);
        check("cx_aborted", aborted, 1);
        cancel = '0;
        req    = '0;
        step();
        check("cx_idle", busy, 0);
        check("cx_aborted_clr", aborted, 0);

        load_val[0*W +: W] = 8'd2;
        req = 4'b0001;
        step(4);
        check("tie_timeout", timer_timeout, 1);
        cancel = 4'b0001;
        step();
        check("tie_done", done, 4'b0001);
        check("tie_aborted", aborted, 0);
        cancel = '0;
        req    = '0;
        step();
        check("tie_idle", busy, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors %0d", n_errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/timer_sched.md
# timer_sched

Round-robin scheduler that shares one `timer` instance between `NREQ` requesters. Each requester asks for a one-shot delay of a given length. The scheduler picks one requester at a time, loads and enables the timer for that request, and waits for `timeout`. It then signals completion to that requester and serves the next one. It sits between client logic and the shared `timer`, and drives every timer input.

## Interface
Parameters:
- `NREQ`, default 4: number of requesters, from 2 to 16.
- `W`, default 32: timer width; matches `timer_load`/`timervalue`.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `req` in NREQ: level request per requester.
- `load_val` in NREQ*W: delay per requester; slice i is `[i*W +: W]`.
- `grant` out NREQ: one-hot; marks the current owner in LOAD/RUN/DONE.
- `done` out NREQ: one-cycle completion pulse to the owner.
- `busy` out 1: high in any state other than IDLE.
- `timer_enable` out W→1: drives `timer.enable`.
- `timer_load` out W: drives `timer.timer_load`.
- `timer_timeout` in 1: from `timer.timeout`.
- `timer_value` in W: from `timer.timervalue`; used only for `remaining`.
- `remaining` out W: `timer_value` while in RUN, else 0.

## Operation
Timer contract:
- While `enable`=0, the timer captures `timer_load` every clock.
- While `enable`=1, it decrements each clock and saturates at 0.
- `timeout` is high combinationally when enabled and value==0.

FSM states and transitions:
- IDLE: if any `req` is set, the arbiter picks the winner. Latch the owner index and `load_val[owner]`, then go to LOAD.
- LOAD: `grant`=owner, `timer_enable`=0, `timer_load`=latched value. Go to RUN after one cycle.
- RUN: `timer_enable`=1. When `timer_timeout`=1, go to DONE.
- DONE: `done[owner]`=1 for one cycle and `timer_enable`=0. Advance the round-robin pointer to the owner, then go to IDLE.

Arbitration:
- Search starts at pointer+1 and wraps modulo `NREQ`.
- After reset the pointer is `NREQ-1`, so index 0 is checked first.

Handshake:
- A requester holds `req` and `load_val` until it sees `done`.
- `load_val` is sampled only on the IDLE→LOAD transition; later changes are ignored.
- If `req` is still high after `done`, that is a new request. It competes behind other pending requesters because the pointer has moved past it.
- Dropping `req` while owner has no effect; the transaction runs to completion.

Width: `timer_load` is exactly W bits; there is no arithmetic on it.

## Timing
Reset (`rst`=0 at an edge):
- State IDLE, pointer `NREQ-1`.
- `grant`, `done`, `busy`, `timer_enable`, `timer_load`, `remaining` all 0.
- Applies even mid-RUN; an in-flight request is dropped with no `done`.

Latency, with `req` first sampled in IDLE at edge t and L = `load_val`:
- LOAD in cycle t+1.
- RUN from t+2.
- `timeout` at t+2+L.
- `done` pulse at t+3+L.
- IDLE at t+4+L.
- The next grant's LOAD is at t+5+L, giving a minimum back-to-back period of L+4 cycles.

Boundary cases:
- L=0: timeout in the first RUN cycle and `done` at t+3. No special path.
- L=2^W−1: no overflow handling; the wait is simply long.
- A `req` arriving while busy waits; there is no preemption.
- Simultaneous requests: exactly one wins, by pointer order.

## Configuration
`TIMER_SCHED_CANCEL_EN` adds an input `cancel` (NREQ) and an output `aborted` (1).
- In LOAD or RUN, `cancel[owner]`=1 moves the FSM to DONE next cycle.
- That DONE cycle pulses `done[owner]` with `aborted`=1.
- If `cancel` and `timer_timeout` arrive in the same cycle, it is a normal completion with `aborted`=0.
- `cancel` from a non-owner is ignored.
- `aborted` resets to 0.
- Without the macro, neither port exists and behaviour is as above.

## Structure
- `timer_sched_pkg`: FSM state encoding (IDLE/LOAD/RUN/DONE), a `clog2`-based index-width constant, and the reset pointer value.
- Sub-module `rr_arbiter`: combinational round-robin pick from `req` and the pointer, outputting a one-hot grant and its index. The pointer register stays in `timer_sched`.

## Test plan
- Single request: reset, then req[1]=1 with load_val[1]=10 → grant=0010 from t+1, timer_load=10 in LOAD, done[1] pulse at t+13, busy low at t+14.
- Zero load: req[0] with L=0 → done[0] at t+3, exactly one RUN cycle.
- Contention: req=1111 with L=3 for all, held continuously → service order 0,1,2,3,0, each 7 cycles apart.
- Reset mid-RUN: `rst` low at RUN cycle 4 with L=50 → all outputs 0 next cycle, no done; after release, req[2] is granted first from IDLE with the pointer reset.
- Sampling: change load_val[0] from 5 to 99 during RUN → done still at t+8.
- With `TIMER_SCHED_CANCEL_EN`: L=100, cancel[owner] at RUN cycle 6 → done and aborted next cycle. cancel[1] while owner is 0 → ignored.
